uart_text_writer: RTL

UART_TEXT_WRITER -- requirements
Module: uart_text_writer

---
 rtl/uart_text_writer_pkg.sv | 25 ++
 rtl/uart_text_writer_if.sv | 22 ++
 rtl/uart_text_writer_byte_fifo.sv | 47 ++++
 rtl/uart_text_writer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_text_writer_pkg.sv
// Shared definitions for the UART text writer: FSM encoding, control characters
// and default screen geometry.
package uart_text_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_text_writer_if.sv
// Byte input and text-RAM write bus of the UART text writer, with cursor/status.
interface uart_text_writer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic        overflow;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overflow
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overflow
  );
endinterface

// File: rtl/uart_text_writer_byte_fifo.sv
// Small synchronous FIFO; pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_text_writer.sv
// Turns a stream of received UART bytes into text-RAM writes with a wrapping
// cursor, CR/LF/BS handling and a form-feed clear-screen sweep.
module uart_text_writer
  import uart_text_writer_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_text_writer_if.slave bus
);

  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        adv_q, adv_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] base_q, base_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [6:0]  wr_data_q, wr_data_d;
  logic        ovf_q, ovf_d;

  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [4:0]  row_inc;
  logic [11:0] base_inc;
  logic [11:0] cur_addr;

  byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (bus.rx_valid),
    .din_i   (bus.rx_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Row base tracks row*COLS incrementally so addresses need only an adder.
  assign row_inc  = (row_q == LAST_ROW) ? 5'd0  : row_q + 5'd1;
  assign base_inc = (row_q == LAST_ROW) ? 12'd0 : base_q + COLS_W;
  assign cur_addr = base_q + 12'(col_q);

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    adv_d     = adv_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fifo_pop  = 1'b0;
    ovf_d     = ovf_q | (bus.rx_valid & fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          byte_d   = fifo_dout;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        if (is_printable(byte_q)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = byte_q[6:0];
          adv_d     = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          case (byte_q)
            CH_CR: col_d = 7'd0;
            CH_LF: begin
              row_d  = row_inc;
              base_d = base_inc;
            end
            CH_BS: begin
              // Backspace moves first, then blanks the cell it lands on.
              if (col_q != 7'd0) begin
                col_d     = col_q - 7'd1;
                wr_en_d   = 1'b1;
                wr_addr_d = cur_addr - 12'd1;
                wr_data_d = CH_SPACE[6:0];
                adv_d     = 1'b0;
                state_d   = ST_WRITE;
              end
            end
            CH_FF: begin
              wr_en_d   = 1'b1;
              wr_addr_d = 12'd0;
              wr_data_d = CH_SPACE[6:0];
              state_d   = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
        if (adv_q) begin
          if (col_q == LAST_COL) begin
            col_d  = 7'd0;
            row_d  = row_inc;
            base_d = base_inc;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end

      ST_CLEAR: begin
        // wr_addr_q doubles as the sweep counter.
        if (wr_addr_q == LAST_ADDR) begin
          col_d   = 7'd0;
          row_d   = 5'd0;
          base_d  = 12'd0;
          state_d = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 12'd1;
          wr_data_d = CH_SPACE[6:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    adv_q  <= adv_d;
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.overflow   = ovf_q;

endmodule
